// File: rtl/uop_dispatch_router.sv
// In-order 2-wide decode->RS dispatch queue; routes each uop by its one-hot rs_mask.
// Optional feature macro DISPATCH_STATS_EN adds saturating dispatch/stall counters.
package uop_dispatch_pkg;
    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        src_b;
        logic [3:0]  alu_ctrl;
        logic [3:0]  rs_mask;
    } uop_s;
endpackage

module uop_dispatch_router
    import uop_dispatch_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned NUM_RS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [1:0]             in_valid,
    input  uop_s [1:0]             in_uop,
    output logic                   in_ready,
    input  logic [NUM_RS-1:0]      rs_ready,
    output logic [NUM_RS-1:0]      rs_valid,
    output uop_s [NUM_RS-1:0]      rs_uop,
    output logic                   illegal_uop,
    output logic [$clog2(DEPTH):0] q_count
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]            stat_dispatched,
    output logic [31:0]            stat_stall
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    uop_s             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [PTR_W-1:0] wr_lane1;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] n_enq;
    logic [CNT_W-1:0] n_deq;
    uop_s             h0;
    uop_s             h1;
    logic             h0_legal;
    logic             h1_legal;
    logic             h0_go;
    logic             h1_go;
    logic             enq_fire;

    assign rd_ptr_p1 = rd_ptr + PTR_W'(1);
    assign wr_lane1  = in_valid[0] ? wr_ptr + PTR_W'(1) : wr_ptr;
    assign h0        = mem[rd_ptr];
    assign h1        = mem[rd_ptr_p1];
    assign h0_legal  = $onehot(h0.rs_mask);
    assign h1_legal  = $onehot(h1.rs_mask);

    // Registered count only, so upstream never sees a path from rs_ready.
    assign in_ready  = (count <= CNT_W'(DEPTH - 2));
    assign q_count   = count;
    assign enq_fire  = in_ready && (in_valid != 2'b00) && !flush && !rst;
    assign n_enq     = enq_fire ? (CNT_W'(in_valid[0]) + CNT_W'(in_valid[1])) : '0;
    assign n_deq     = CNT_W'(h0_go) + CNT_W'(h1_go);

    always_comb begin
        h0_go = 1'b0;
        h1_go = 1'b0;
        if (!rst && !flush && (count >= CNT_W'(1))) begin
            h0_go = !h0_legal || ((h0.rs_mask & rs_ready) != '0);
            if (h0_go && (count >= CNT_W'(2))) begin
                // A dropped h0 occupies no RS, so only a legal h0 can conflict.
                h1_go = !h1_legal ||
                        (((h1.rs_mask & rs_ready) != '0) &&
                         !(h0_legal && (h1.rs_mask == h0.rs_mask)));
            end
        end
    end

    always_comb begin
        rs_valid = '0;
        rs_uop   = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (h0_go && h0_legal && h0.rs_mask[i]) begin
                rs_valid[i] = 1'b1;
                rs_uop[i]   = h0;
            end else if (h1_go && h1_legal && h1.rs_mask[i]) begin
                rs_valid[i] = 1'b1;
                rs_uop[i]   = h1;
            end
        end
    end

    assign illegal_uop = (h0_go && !h0_legal) || (h1_go && !h1_legal);

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            if (in_valid[0]) mem[wr_ptr] <= in_uop[0];
            if (in_valid[1]) mem[wr_lane1] <= in_uop[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count + n_enq - n_deq;
            rd_ptr <= rd_ptr + n_deq[PTR_W-1:0];
            wr_ptr <= wr_ptr + n_enq[PTR_W-1:0];
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [32:0] disp_sum;
    logic        h0_blocked;

    assign disp_sum   = {1'b0, stat_dispatched} + 33'(n_deq);
    assign h0_blocked = (count >= CNT_W'(1)) && !flush && !h0_go;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_dispatched <= '0;
            stat_stall      <= '0;
        end else begin
            stat_dispatched <= disp_sum[32] ? 32'hFFFF_FFFF : disp_sum[31:0];
            if (h0_blocked && (stat_stall != 32'hFFFF_FFFF)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`else
    // Statistics disabled: no counters, dispatch behaviour unchanged.
`endif

endmodule
